// File: rtl/ins_queue_reg.sv
// ---------------------------------------------------------------------------
// ins_queue_reg
//   Instruction register with a small prefetch FIFO in front of it. The fetch
//   side pushes instruction words into the FIFO. The control unit pulses loadIR
//   to move the oldest queued word into the IR. The opcode and address fields
//   are decoded from the IR.
//
// Parameters
//   INS_W   instruction word width
//   OP_W    opcode width, opcode = IR[INS_W-1 -: OP_W]
//   ADDR_W  address width, address = IR[ADDR_W-1:0] (INS_W >= OP_W+ADDR_W)
//   DEPTH   queue entries, power of two, >= 2
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   fetch word on insin is valid
//   in_ready   queue can accept a word (= !full)
//   insin      fetched instruction word
//   loadIR     pop the queue head into the IR
//   flush      discard the queue and invalidate the IR (IR data is kept)
//   ir_valid   IR holds a valid instruction
//   opcode     opcode field of the IR
//   address    address field of the IR
//   count      number of queued entries
//   empty      count == 0
//   full       count == DEPTH
//   underflow  sticky flag: loadIR was seen with no word available
//
// Build option
//   INSQ_BYPASS_EN: when the queue is empty and loadIR and in_valid are both
//   high, insin goes straight into the IR instead of through the queue.
//
// Handshake
//   Fetch side: a word transfers on a rising edge where in_valid && in_ready
//   and flush is low. in_ready depends only on registered state, so a word
//   offered while full is simply not taken. The producer keeps in_valid and
//   insin stable until the transfer happens.
// ---------------------------------------------------------------------------
module ins_queue_reg #(
   parameter int INS_W  = 16,
   parameter int OP_W   = 4,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INS_W-1:0]             insin,
   input  logic                         loadIR,
   input  logic                         flush,
   output logic                         ir_valid,
   output logic [OP_W-1:0]              opcode,
   output logic [ADDR_W-1:0]            address,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic                         underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [INS_W-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic [INS_W-1:0] ir;
   logic             ir_vld;
   logic             uflow;

   logic             miss;     // loadIR with nothing queued
   logic             bypass;   // the miss is served directly from insin
   logic             do_push;
   logic             do_pop;

   // Circular pointer advance. The wrap is written out explicitly so the
   // intent is clear, even though DEPTH is a power of two.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // ---------------------------------------------------------------------
   // Status and decode. All of these come only from registers.
   // ---------------------------------------------------------------------
   assign empty     = (cnt == '0);
   assign full      = (cnt == CW'(DEPTH));
   assign in_ready  = !full;
   assign count     = cnt;
   assign ir_valid  = ir_vld;
   assign underflow = uflow;
   assign opcode    = ir[INS_W-1 -: OP_W];
   assign address   = ir[ADDR_W-1:0];

   // ---------------------------------------------------------------------
   // Transfer decisions. Flush overrides every other action.
   // ---------------------------------------------------------------------
   always_comb begin
      bypass = 1'b0;
      miss   = loadIR & empty & !flush;
`ifdef INSQ_BYPASS_EN
      bypass = miss & in_valid;
`endif
      // In the bypass case the word goes to the IR, so it must not also be
      // queued.
      do_push = in_valid & !full & !flush & !bypass;
      do_pop  = loadIR & !empty & !flush;
   end

   // ---------------------------------------------------------------------
   // Queue storage. This array has no reset. An entry is read only after it
   // has been written, because cnt gates every pop.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= insin;
      end
   end

   // ---------------------------------------------------------------------
   // Pointers, occupancy and IR state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ir     <= '0;
         ir_vld <= 1'b0;
         uflow  <= 1'b0;
      end else if (flush) begin
         // IR data is kept on purpose: the decoded fields keep showing the
         // stale instruction, and ir_valid marks it as invalid.
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ir_vld <= 1'b0;
         uflow  <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end

         // A push and a pop in the same cycle leave cnt unchanged.
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase

         if (do_pop) begin
            ir     <= mem[rd_ptr];
            ir_vld <= 1'b1;
         end else if (bypass) begin
            ir     <= insin;
            ir_vld <= 1'b1;
         end else if (miss) begin
            // No word is available: the IR keeps its old bits but is no
            // longer valid, and the miss is recorded until flush or reset.
            ir_vld <= 1'b0;
            uflow  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ins_queue_reg.sv
// ---------------------------------------------------------------------------
// tb_ins_queue_reg
//   Directed bench for ins_queue_reg at its default parameters. Expected
//   values are hand constants where the scenario gives them. A small queue
//   model (exp_q) covers the longer push/pop runs. Define INSQ_BYPASS_EN to
//   build this bench against the bypass build.
// ---------------------------------------------------------------------------
module tb_ins_queue_reg;

   localparam int INS_W  = 16;
   localparam int OP_W   = 4;
   localparam int ADDR_W = 12;
   localparam int DEPTH  = 4;
   localparam int CW     = $clog2(DEPTH + 1);
`ifdef INSQ_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [INS_W-1:0]  insin;
   logic              loadIR;
   logic              flush;
   logic              ir_valid;
   logic [OP_W-1:0]   opcode;
   logic [ADDR_W-1:0] address;
   logic [CW-1:0]     count;
   logic              empty;
   logic              full;
   logic              underflow;

   always #5 clk = ~clk;

   ins_queue_reg #(
      .INS_W (INS_W),
      .OP_W  (OP_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .insin    (insin),
      .loadIR   (loadIR),
      .flush    (flush),
      .ir_valid (ir_valid),
      .opcode   (opcode),
      .address  (address),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .underflow(underflow)
   );

   // ---------------- scoreboard state ----------------
   int               pass_cnt  = 0;
   int               fail_cnt  = 0;
   int               total_cnt = 0;
   logic [INS_W-1:0] exp_q[$];
   logic [INS_W-1:0] exp_ir;
   logic             exp_irv;
   logic             exp_uf;
   logic [INS_W-1:0] word;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare every output with the queue model.
   task automatic check_model(input string tag);
      check({tag, ".count"},     32'(count),                    32'(exp_q.size()));
      check({tag, ".ir_valid"},  32'(ir_valid),                 32'(exp_irv));
      check({tag, ".ir"},        32'({opcode, address}),        32'(exp_ir));
      check({tag, ".underflow"}, 32'(underflow),                32'(exp_uf));
      check({tag, ".empty"},     32'(empty),                    32'(exp_q.size() == 0));
      check({tag, ".full"},      32'(full),                     32'(exp_q.size() == DEPTH));
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_ir  = '0;
      exp_irv = 1'b0;
      exp_uf  = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, update the model for that edge, then return
   // #1 after the edge with all inputs idle.
   task automatic drive(input logic v, input logic [INS_W-1:0] w,
                        input logic ld, input logic fl);
      bit m_miss, m_byp, m_pop, m_push;
      in_valid = v;
      insin    = w;
      loadIR   = ld;
      flush    = fl;
      if (fl) begin
         exp_q.delete();
         exp_irv = 1'b0;
         exp_uf  = 1'b0;
      end else begin
         m_miss = ld && (exp_q.size() == 0);
         m_byp  = m_miss && v && BYPASS;
         m_pop  = ld && (exp_q.size() != 0);
         m_push = v && (exp_q.size() < DEPTH) && !m_byp;
         if (m_pop) begin
            exp_ir  = exp_q.pop_front();
            exp_irv = 1'b1;
         end else if (m_byp) begin
            exp_ir  = w;
            exp_irv = 1'b1;
         end else if (m_miss) begin
            exp_irv = 1'b0;
            exp_uf  = 1'b1;
         end
         if (m_push) begin
            exp_q.push_back(w);
         end
      end
      tick();
      in_valid = 1'b0;
      insin    = '0;
      loadIR   = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic push(input logic [INS_W-1:0] w);
      drive(1'b1, w, 1'b0, 1'b0);
   endtask

   task automatic pop();
      drive(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".ir_valid"},  32'(ir_valid),  32'h0);
      check({tag, ".opcode"},    32'(opcode),    32'h0);
      check({tag, ".address"},   32'(address),   32'h0);
      check({tag, ".count"},     32'(count),     32'h0);
      check({tag, ".empty"},     32'(empty),     32'h1);
      check({tag, ".full"},      32'(full),      32'h0);
      check({tag, ".in_ready"},  32'(in_ready),  32'h1);
      check({tag, ".underflow"}, 32'(underflow), 32'h0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      insin    = '0;
      loadIR   = 1'b0;
      flush    = 1'b0;
      model_reset();
      tick();
      tick();
      check_reset_values("rst");
      reset = 1'b0;
      tick();

      // Two pushes, then two pops. Each IR shows up one clock after its edge.
      push(16'h1234);
      push(16'hABCD);
      check("t2.count", 32'(count), 32'd2);
      pop();
      check("t2.op1",   32'(opcode),   32'h1);
      check("t2.addr1", 32'(address),  32'h234);
      check("t2.irv1",  32'(ir_valid), 32'h1);
      pop();
      check("t2.op2",   32'(opcode),   32'hA);
      check("t2.addr2", 32'(address),  32'hBCD);
      check("t2.empty", 32'(empty),    32'h1);

      // Fill to full. The fifth word must be dropped.
      for (int k = 1; k <= 4; k++) begin
         push(16'(k * 16'h1001));
      end
      check("t3.full",     32'(full),     32'h1);
      check("t3.in_ready", 32'(in_ready), 32'h0);
      check("t3.count",    32'(count),    32'd4);
      push(16'h5005);
      check("t3.count5",   32'(count),    32'd4);
      for (int k = 1; k <= 4; k++) begin
         pop();
         word = 16'(k * 16'h1001);
         check($sformatf("t3.pop%0d", k), 32'({opcode, address}), 32'(word));
      end
      check("t3.empty", 32'(empty), 32'h1);

      // Pointer wrap: push and pop together at count 3.
      push(16'h6100);
      push(16'h6201);
      push(16'h6302);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 16'(16'h6403 + i), 1'b1, 1'b0);
         check_model($sformatf("t4.step%0d", i));
         check($sformatf("t4.count%0d", i), 32'(count), 32'd3);
      end
      for (int i = 0; i < 3; i++) begin
         pop();
         check_model($sformatf("t4.drain%0d", i));
      end

      // loadIR and in_valid together while the queue is empty
      drive(1'b1, 16'h5007, 1'b1, 1'b0);
`ifdef INSQ_BYPASS_EN
      check("t6.op",    32'(opcode),    32'h5);
      check("t6.addr",  32'(address),   32'h007);
      check("t6.irv",   32'(ir_valid),  32'h1);
      check("t6.count", 32'(count),     32'd0);
      check("t6.uf",    32'(underflow), 32'h0);
`else
      check("t6.uf",    32'(underflow), 32'h1);
      check("t6.count", 32'(count),     32'd1);
      check("t6.irv",   32'(ir_valid),  32'h0);
      check("t6.ir_hold", 32'({opcode, address}), 32'h6408);
      pop();
      check("t6.op",    32'(opcode),    32'h5);
      check("t6.addr",  32'(address),   32'h007);
      check("t6.uf_sticky", 32'(underflow), 32'h1);
`endif
      check_model("t6.model");

      // Flush with push and pop in the same cycle
      push(16'h8123);
      push(16'h9456);
      check("t5.count_pre", 32'(count),    32'd2);
      check("t5.irv_pre",   32'(ir_valid), 32'h1);
      drive(1'b1, 16'hC0DE, 1'b1, 1'b1);
      check("t5.count", 32'(count),              32'd0);
      check("t5.irv",   32'(ir_valid),           32'h0);
      check("t5.ir",    32'({opcode, address}), 32'h5007);
      check("t5.empty", 32'(empty),              32'h1);
      check("t5.uf",    32'(underflow),          32'h0);
      // loadIR on an empty queue with no word offered
      pop();
      check("t5.uf_set", 32'(underflow),          32'h1);
      check("t5.irv_miss", 32'(ir_valid),         32'h0);
      check("t5.ir_hold", 32'({opcode, address}), 32'h5007);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("t5.uf_clr", 32'(underflow), 32'h0);

      // Asynchronous reset in the middle of a cycle
      push(16'h2111);
      push(16'h2222);
      push(16'h2333);
      pop();
      check("t1.count_pre", 32'(count),              32'd2);
      check("t1.irv_pre",   32'(ir_valid),           32'h1);
      check("t1.ir_pre",    32'({opcode, address}), 32'h2111);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_values("t1.async");
      #3;
      reset = 1'b0;
      tick();
      push(16'h7ABC);
      check("t1.count_post", 32'(count), 32'd1);
      pop();
      check("t1.op_post",   32'(opcode),  32'h7);
      check("t1.addr_post", 32'(address), 32'hABC);
      check_model("t1.model");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
